// File: rtl/timer_pkg.sv
// Shared timer constants: prescaler width, divider-select width and prescaler reset value.
// The timer counter uses the same widths so that the timebase and the counter always agree.
package timer_pkg;

    localparam int TMR_CNT_W = 8;
    localparam int TMR_SEL_W = 3;

    localparam logic [TMR_CNT_W-1:0] TMR_CNT_RST = '0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the pclk domain.
// Latency: 2 pclk from a stable input to q.
// Backpressure: none; samples every pclk, input pulses must last at least 2 pclk.
module sync_2ff (
    input  logic pclk,
    input  logic presetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/timer_clk_gen.sv
// Timer timebase: divided-pclk prescaler or synchronized external tick, switched glitch-free.
// Latency: clk_int 1 pclk after cnt in internal mode, 3 pclk after ext_clk in external mode.
// Backpressure: none; select changes wait for the prescaler wrap and are flagged on sel_busy.
module timer_clk_gen
    import timer_pkg::*;
#(
    parameter int CNT_W = TMR_CNT_W,
    parameter int SEL_W = TMR_SEL_W
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             div_en,
    input  logic [SEL_W-1:0] div_sel,
    input  logic             ext_sel,
    input  logic             ext_clk,
    output logic             clk_int,
    output logic             sel_busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TMR_CNT_RST);

    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel_act;
    logic             ext_act;
    logic             ext_sync;
    logic             cnt_wrap;
    logic             sel_load;
    logic             sel_diff;
    logic             clk_nxt;

    sync_2ff u_sync (
        .pclk    (pclk),
        .presetn (presetn),
        .d       (ext_clk),
        .q       (ext_sync)
    );

    // Every selected cnt bit is high at the wrap, so switching there cannot
    // shorten a high phase or create an extra rising edge.
    always_comb begin
        cnt_wrap = (cnt == '1);
        sel_load = !div_en || cnt_wrap;
        sel_diff = (div_sel != sel_act) || (ext_sel != ext_act);
        clk_nxt  = 1'b0;
        if (div_en) begin
            clk_nxt = ext_act ? ext_sync : cnt[sel_act];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= CNT_INIT;
        end else if (!div_en) begin
            cnt <= CNT_INIT;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sel_act <= '0;
            ext_act <= 1'b0;
        end else if (sel_load) begin
            sel_act <= div_sel;
            ext_act <= ext_sel;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            clk_int  <= 1'b0;
            sel_busy <= 1'b0;
        end else begin
            clk_int  <= clk_nxt;
            sel_busy <= sel_diff;
        end
    end

endmodule

// File: tb/tb_timer_clk_gen.sv
// Directed bench for timer_clk_gen: prescaler divide ratios, deferred select switching,
// external tick path, enable drop/restart and asynchronous reset.
module tb_timer_clk_gen;

    logic       pclk;
    logic       presetn;
    logic       div_en;
    logic [2:0] div_sel;
    logic       ext_sel;
    logic       ext_clk;
    logic       clk_int;
    logic       sel_busy;

    int checks = 0;
    int errors = 0;

    timer_clk_gen dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .div_en   (div_en),
        .div_sel  (div_sel),
        .ext_sel  (ext_sel),
        .ext_clk  (ext_clk),
        .clk_int  (clk_int),
        .sel_busy (sel_busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] e;
        logic        hist [0:59];
        logic        prev_clk;
        int          rises;

        presetn = 1'b0;
        div_en  = 1'b0;
        div_sel = 3'd0;
        ext_sel = 1'b0;
        ext_clk = 1'b0;
        #12;
        chk("rst_clk_int", clk_int, 0);
        chk("rst_sel_busy", sel_busy, 0);
        chk("rst_cnt", dut.cnt, 0);
        chk("rst_sel_act", dut.sel_act, 0);

        // sel=0: toggles every pclk, first rise on the 2nd enabled edge
        presetn = 1'b1;
        div_en  = 1'b1;
        tick(1);
        chk("sel0_edge1_clk", clk_int, 0);
        chk("sel0_edge1_cnt", dut.cnt, 1);
        for (int n = 2; n <= 10; n++) begin
            tick(1);
            e = (n - 1) & 1;
            chk("sel0_clk", clk_int, e);
        end

        // Load sel=3 while disabled; sel_busy reports the one-cycle-late compare
        div_en  = 1'b0;
        div_sel = 3'd3;
        tick(1);
        chk("dis_clk_zero", clk_int, 0);
        chk("dis_cnt_zero", dut.cnt, 0);
        chk("busy_after_load", sel_busy, 1);
        tick(1);
        chk("busy_cleared", sel_busy, 0);

        // sel=3 period 16, switch to sel=1 written at cnt=0x40, applied at wrap
        div_en = 1'b1;
        for (int n = 1; n <= 280; n++) begin
            tick(1);
            e = (((n - 1) % 256) >> ((n <= 256) ? 3 : 1)) & 1;
            chk("switch_clk", clk_int, e);
            chk("switch_busy", sel_busy, (n >= 65 && n <= 256) ? 1 : 0);
            if (n == 64) begin
                chk("cnt_at_0x40", dut.cnt, 32'h40);
                div_sel = 3'd1;
            end
        end
        chk("sel_act_after_wrap", dut.sel_act, 1);

        // sel=2, drop div_en at cnt=5, then restart from 0
        div_en  = 1'b0;
        div_sel = 3'd2;
        tick(1);
        div_en = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick(1);
            e = ((n - 1) >> 2) & 1;
            chk("sel2_clk", clk_int, e);
        end
        chk("sel2_cnt5", dut.cnt, 5);
        div_en = 1'b0;
        tick(1);
        chk("drop_clk_zero", clk_int, 0);
        chk("drop_cnt_zero", dut.cnt, 0);
        div_en = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick(1);
            e = ((n - 1) >> 2) & 1;
            chk("reen_clk", clk_int, e);
        end

        // External mode: ext_clk toggles every 5 pclk, clk_int follows 3 cycles later
        div_en  = 1'b0;
        ext_sel = 1'b1;
        tick(1);
        chk("ext_load_busy", sel_busy, 1);
        div_en   = 1'b1;
        rises    = 0;
        prev_clk = clk_int;
        for (int i = 0; i < 60; i++) begin
            hist[i] = ((i / 5) % 2) == 1;
            ext_clk = hist[i];
            tick(1);
            e = (i >= 2) ? 32'(hist[i-2]) : 32'd0;
            chk("ext_clk_follow", clk_int, e);
            if (clk_int && !prev_clk) rises++;
            prev_clk = clk_int;
        end
        chk("ext_rise_count", rises, 6);
        div_en = 1'b0;
        tick(1);
        chk("ext_dis_clk_zero", clk_int, 0);
        div_en = 1'b1;
        tick(1);
        chk("ext_sync_kept", clk_int, 1);

        // Back to internal, sel=4, reset mid high phase
        ext_clk = 1'b0;
        ext_sel = 1'b0;
        div_sel = 3'd4;
        div_en  = 1'b0;
        tick(1);
        div_en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick(1);
            e = ((n - 1) >> 4) & 1;
            chk("sel4_clk", clk_int, e);
        end
        presetn = 1'b0;
        #2;
        chk("arst_clk_int", clk_int, 0);
        chk("arst_cnt", dut.cnt, 0);
        chk("arst_sel_act", dut.sel_act, 0);
        chk("arst_sel_busy", sel_busy, 0);
        div_en  = 1'b0;
        presetn = 1'b1;
        tick(1);
        chk("post_rst_busy", sel_busy, 1);
        div_en = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick(1);
            e = ((n - 1) >> 4) & 1;
            chk("restart_clk", clk_int, e);
            if (n == 1) chk("restart_cnt1", dut.cnt, 1);
        end
        chk("restart_busy", sel_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
